// File: rtl/alu_pkg.sv
// Shared definitions for the iterative 74181-style ALU: select width, named S codes, FSM states.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  // S codes; SUB and XOR share an encoding and differ only in the mode bit
  localparam logic [ALU_OP_W-1:0] ALU_S_ADD = 4'b1001;
  localparam logic [ALU_OP_W-1:0] ALU_S_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_S_XOR = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_S_AND = 4'b1011;

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/alu_4.sv
// 4-bit 74181 slice, active-high data, active-low carry in/out; no lookahead outputs.
module alu_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // g is always a subset of p, so the arithmetic result is p + g + carry
  always_comb begin
    g = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    f   = g ^ p ^ (c[3:0] | {4{m}});
    cn4 = ~c[4];
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle WIDTH-bit 74181 ALU: LANES nibble slices per clock, carry registered between chunks.
// Optional zero flag is enabled by defining ALU_ITER_ZERO_EN.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic                mode,
  input  logic [WIDTH-1:0]    x,
  input  logic [WIDTH-1:0]    y,
  input  logic                c_in,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    z,
  output logic                c_out8,
  output logic                c_out_msb
`ifdef ALU_ITER_ZERO_EN
  ,
  output logic                zero
`endif
);

  localparam int CW     = 4 * LANES;
  localparam int CYCLES = WIDTH / CW;
  localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int C8_LANE = 1 % LANES;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] C8_K = CNT_W'(1 / LANES);

  state_t                state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ALU_OP_W-1:0]   op_reg;
  logic                  mode_reg;
  logic                  carry_reg;
  logic                  c8_reg;
  logic [WIDTH-1:0]      a_reg;
  logic [WIDTH-1:0]      b_reg;
  logic [WIDTH-1:0]      acc_reg;
  logic [WIDTH-1:0]      acc_next;
  logic [CW-1:0]         chunk_f;
  logic [LANES:0]        cn_chain;
`ifdef ALU_ITER_ZERO_EN
  logic                  nz_reg;
`endif

  assign cn_chain[0] = carry_reg;
  assign busy        = (state_reg == RUN);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      alu_4 u_slice (
        .a   (a_reg[4*gi +: 4]),
        .b   (b_reg[4*gi +: 4]),
        .s   (op_reg),
        .m   (mode_reg),
        .cn  (cn_chain[gi]),
        .f   (chunk_f[4*gi +: 4]),
        .cn4 (cn_chain[gi+1])
      );
    end
    // Chunks enter at the top and shift down, so chunk 0 lands at bit 0 after the last one
    if (CYCLES == 1) begin : g_acc_single
      assign acc_next = chunk_f;
    end else begin : g_acc_shift
      assign acc_next = {chunk_f, acc_reg[WIDTH-1:CW]};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      mode_reg  <= 1'b0;
      carry_reg <= 1'b1;
      c8_reg    <= 1'b1;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      done      <= 1'b0;
      z         <= '0;
      c_out8    <= 1'b1;
      c_out_msb <= 1'b1;
`ifdef ALU_ITER_ZERO_EN
      nz_reg    <= 1'b0;
      zero      <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg    <= alu_op;
            mode_reg  <= mode;
            a_reg     <= x;
            b_reg     <= y;
            carry_reg <= c_in;
            cnt_reg   <= '0;
`ifdef ALU_ITER_ZERO_EN
            nz_reg    <= 1'b0;
`endif
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> CW;
          b_reg     <= b_reg >> CW;
          acc_reg   <= acc_next;
          carry_reg <= cn_chain[LANES];
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == C8_K) c8_reg <= cn_chain[C8_LANE+1];
`ifdef ALU_ITER_ZERO_EN
          nz_reg    <= nz_reg | (|chunk_f);
`endif
          if (cnt_reg == LAST) begin
            z         <= acc_next;
            c_out8    <= (LAST == C8_K) ? cn_chain[C8_LANE+1] : c8_reg;
            c_out_msb <= cn_chain[LANES];
`ifdef ALU_ITER_ZERO_EN
            zero      <= ~(nz_reg | (|chunk_f));
`endif
            done      <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: W=16/L=1 and W=32/L=4 instances checked every cycle against a datasheet model.
module tb_alu_iter;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] z;
    logic        c8;
    logic        cm;
    logic        zr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic        st16 = 0, m16 = 0, ci16 = 1;
  logic [3:0]  s16 = 0;
  logic [15:0] x16 = 0, y16 = 0;
  logic        busy16, done16, c8_16, cm16;
  logic [15:0] z16;
  logic        st32 = 0, m32 = 0, ci32 = 1;
  logic [3:0]  s32 = 0;
  logic [31:0] x32 = 0, y32 = 0;
  logic        busy32, done32, c8_32, cm32;
  logic [31:0] z32;
`ifdef ALU_ITER_ZERO_EN
  logic        zr16, zr32;
  localparam logic ZEN = 1'b1;
`else
  localparam logic ZEN = 1'b0;
`endif

  alu_iter #(.WIDTH(16), .LANES(1)) dut16 (
    .clk(clk), .reset(reset), .start(st16), .alu_op(s16), .mode(m16),
    .x(x16), .y(y16), .c_in(ci16), .busy(busy16), .done(done16),
    .z(z16), .c_out8(c8_16), .c_out_msb(cm16)
`ifdef ALU_ITER_ZERO_EN
    , .zero(zr16)
`endif
  );

  alu_iter #(.WIDTH(32), .LANES(4)) dut32 (
    .clk(clk), .reset(reset), .start(st32), .alu_op(s32), .mode(m32),
    .x(x32), .y(y32), .c_in(ci32), .busy(busy32), .done(done32),
    .z(z32), .c_out8(c8_32), .c_out_msb(cm32)
`ifdef ALU_ITER_ZERO_EN
    , .zero(zr32)
`endif
  );

  exp_t q16[$];
  exp_t q32[$];
  exp_t held[2];

  // Datasheet function table: logic results for M=1, arithmetic as u plus v plus carry
  function automatic exp_t model(input logic [3:0] s, input logic m, input logic [31:0] ai,
                                 input logic [31:0] bi, input logic cn, input int w);
    exp_t e;
    logic [32:0] mask, a, b, na, nb, u, v, sum;
    logic [8:0]  s8;
    logic [32:0] f;
    mask = (33'd1 << w) - 33'd1;
    a = {1'b0, ai} & mask;
    b = {1'b0, bi} & mask;
    na = ~a & mask;
    nb = ~b & mask;
    case (s)
      4'd0:  begin u = a;      v = '0;     end
      4'd1:  begin u = a | b;  v = '0;     end
      4'd2:  begin u = a | nb; v = '0;     end
      4'd3:  begin u = mask;   v = '0;     end
      4'd4:  begin u = a;      v = a & nb; end
      4'd5:  begin u = a | b;  v = a & nb; end
      4'd6:  begin u = a;      v = nb;     end
      4'd7:  begin u = a & nb; v = mask;   end
      4'd8:  begin u = a;      v = a & b;  end
      4'd9:  begin u = a;      v = b;      end
      4'd10: begin u = a | nb; v = a & b;  end
      4'd11: begin u = a & b;  v = mask;   end
      4'd12: begin u = a;      v = a;      end
      4'd13: begin u = a | b;  v = a;      end
      4'd14: begin u = a | nb; v = a;      end
      default: begin u = a;    v = mask;   end
    endcase
    sum = u + v + {32'd0, ~cn};
    s8 = {1'b0, u[7:0]} + {1'b0, v[7:0]} + {8'd0, ~cn};
    if (m) begin
      case (s)
        4'd0:  f = na;
        4'd1:  f = ~(a | b) & mask;
        4'd2:  f = na & b;
        4'd3:  f = '0;
        4'd4:  f = ~(a & b) & mask;
        4'd5:  f = nb;
        4'd6:  f = a ^ b;
        4'd7:  f = a & nb;
        4'd8:  f = na | b;
        4'd9:  f = ~(a ^ b) & mask;
        4'd10: f = b;
        4'd11: f = a & b;
        4'd12: f = mask;
        4'd13: f = a | nb;
        4'd14: f = a | b;
        default: f = a;
      endcase
    end else begin
      f = sum & mask;
    end
    e.z = f[31:0];
    e.c8 = ~s8[8];
    e.cm = ~sum[w];
    e.zr = (f == 0);
    e.due = 0;
    return e;
  endfunction

  function automatic exp_t lit(input logic [31:0] z, input logic c8, input logic cm, input logic zr);
    exp_t e;
    e.z = z; e.c8 = c8; e.cm = cm; e.zr = zr; e.due = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Per-cycle check: done/busy timing from the queue head, outputs against last completed result
  task automatic mon(input int d);
    exp_t e;
    logic has, edone, dn, bz, c8o, cmo, zro;
    logic [31:0] zo;
    zro = 1'b0;
    if (reset) begin
      if (d == 0) q16.delete(); else q32.delete();
      held[d] = lit(32'd0, 1'b1, 1'b1, 1'b1);
    end
    if (d == 0) begin
      has = (q16.size() > 0); if (has) e = q16[0];
      dn = done16; bz = busy16; zo = {16'd0, z16}; c8o = c8_16; cmo = cm16;
`ifdef ALU_ITER_ZERO_EN
      zro = zr16;
`endif
    end else begin
      has = (q32.size() > 0); if (has) e = q32[0];
      dn = done32; bz = busy32; zo = z32; c8o = c8_32; cmo = cm32;
`ifdef ALU_ITER_ZERO_EN
      zro = zr32;
`endif
    end
    edone = has && (cyc == e.due);
    chk(d == 0 ? "done16" : "done32", {63'd0, dn}, {63'd0, edone});
    chk(d == 0 ? "busy16" : "busy32", {63'd0, bz}, {63'd0, has && !edone});
    if (edone) begin
      held[d] = e;
      if (d == 0) void'(q16.pop_front()); else void'(q32.pop_front());
      $display("cyc=%0d dut%0d done z=%h c8=%b cm=%b", cyc, d, zo, c8o, cmo);
    end
    chk(d == 0 ? "out16" : "out32", {29'd0, zo, c8o, cmo, zro & ZEN},
        {29'd0, held[d].z, held[d].c8, held[d].cm, held[d].zr & ZEN});
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic drain();
    for (int i = 0; i < 40 && (q16.size() + q32.size()) > 0; i++) @(posedge clk);
    chk("drain", 64'(q16.size() + q32.size()), 64'd0);
  endtask

  task automatic run16(input logic [3:0] s, input logic m, input logic [15:0] a, input logic [15:0] b,
                       input logic cn, input exp_t e);
    exp_t t;
    @(posedge clk); #1;
    st16 = 1; s16 = s; m16 = m; x16 = a; y16 = b; ci16 = cn;
    @(posedge clk); #1;
    t = e; t.due = cyc + 4; q16.push_back(t);
    st16 = 0; x16 = 16'($urandom); y16 = 16'($urandom);
    drain();
  endtask

  task automatic run32(input logic [3:0] s, input logic m, input logic [31:0] a, input logic [31:0] b,
                       input logic cn, input exp_t e);
    exp_t t;
    @(posedge clk); #1;
    st32 = 1; s32 = s; m32 = m; x32 = a; y32 = b; ci32 = cn;
    @(posedge clk); #1;
    t = e; t.due = cyc + 2; q32.push_back(t);
    st32 = 0; x32 = $urandom; y32 = $urandom;
    drain();
  endtask

  initial begin
    exp_t t;
    logic [31:0] ra, rb;
    logic rc;
    #2 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;

    run16(ALU_S_ADD, 1'b0, 16'h00FF, 16'h0001, 1'b1, lit(32'h0100, 1'b0, 1'b1, 1'b0));
    run16(ALU_S_ADD, 1'b0, 16'hFFFF, 16'h0001, 1'b1, lit(32'h0000, 1'b0, 1'b0, 1'b1));
    run16(ALU_S_XOR, 1'b1, 16'hA5A5, 16'hFFFF, 1'b1, lit(32'h5A5A, 1'b1, 1'b1, 1'b0));
    run16(ALU_S_SUB, 1'b0, 16'h0005, 16'h0003, 1'b0, lit(32'h0002, 1'b0, 1'b0, 1'b0));
    run16(ALU_S_AND, 1'b1, 16'hF0F0, 16'h3C3C, 1'b1, lit(32'h3030, 1'b0, 1'b0, 1'b0));

    // start held through RUN with changing x: only the IDLE edges sample operands
    @(posedge clk); #1;
    st16 = 1; s16 = ALU_S_ADD; m16 = 0; x16 = 16'h00FF; y16 = 16'h0001; ci16 = 1;
    @(posedge clk); #1;
    t = lit(32'h0100, 1'b0, 1'b1, 1'b0); t.due = cyc + 4; q16.push_back(t);
    for (int i = 0; i < 4; i++) begin
      x16 = 16'($urandom);
      @(posedge clk); #1;
    end
    x16 = 16'h1234;
    @(posedge clk); #1;
    t = lit(32'h1235, 1'b1, 1'b1, 1'b0); t.due = cyc + 4; q16.push_back(t);
    st16 = 0;
    drain();

    // reset on the second RUN cycle aborts with no done and clears the result
    @(posedge clk); #1;
    st16 = 1; s16 = ALU_S_ADD; m16 = 0; x16 = 16'h1111; y16 = 16'h2222; ci16 = 1;
    @(posedge clk); #1;
    t = lit(32'h3333, 1'b1, 1'b1, 1'b0); t.due = cyc + 4; q16.push_back(t);
    st16 = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("abort_busy", {63'd0, busy16}, 64'd0);
    chk("abort_z", {48'd0, z16}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1 reset = 0;
    run16(ALU_S_ADD, 1'b0, 16'h1111, 16'h2222, 1'b1, lit(32'h3333, 1'b1, 1'b1, 1'b0));

    run32(ALU_S_ADD, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b1, lit(32'h80000000, 1'b0, 1'b1, 1'b0));
    run32(ALU_S_ADD, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b1, lit(32'h0, 1'b0, 1'b0, 1'b1));

    for (int s = 0; s < 16; s++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 2; k++) begin
          ra = $urandom; rb = $urandom; rc = 1'($urandom);
          run32(4'(s), 1'(m), ra, rb, rc, model(4'(s), 1'(m), ra, rb, rc, 32));
          ra = $urandom; rb = $urandom; rc = 1'($urandom);
          run16(4'(s), 1'(m), ra[15:0], rb[15:0], rc, model(4'(s), 1'(m), ra, rb, rc, 16));
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
